// File: rtl/osc_bank_mixer.sv
`default_nettype none
// ============================================================================
// osc_bank_mixer: time-multiplexed oscillator bank, one shared datapath
// evaluating N_CH channels per sample tick, mixed and scaled by 1/N_CH.
// Rev 1.0
// ============================================================================
module osc_bank_mixer #(
  parameter int N_CH  = 4,
  parameter int FCW_W = 24,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_tick,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [1:0]        i_cfg_sel,
  input  logic [FCW_W-1:0]  i_cfg_data,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
  localparam int          c_SUM_W     = 16 + CH_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_sh_wave  [N_CH];
  logic [FCW_W-1:0]  r_sh_fcw   [N_CH];
  logic [15:0]       r_sh_phase [N_CH];
  logic [15:0]       r_sh_amp   [N_CH];
  logic [2:0]        w_sh_wave  [N_CH];
  logic [FCW_W-1:0]  w_sh_fcw   [N_CH];
  logic [15:0]       w_sh_phase [N_CH];
  logic [15:0]       w_sh_amp   [N_CH];
  logic [2:0]        r_act_wave [N_CH];
  logic [FCW_W-1:0]  r_act_fcw  [N_CH];
  logic [15:0]       r_act_phase[N_CH];
  logic [15:0]       r_act_amp  [N_CH];
  logic [FCW_W-1:0]  r_acc      [N_CH];

  logic [CH_W-1:0]          r_ch;
  logic [15:0]              r_lfsr;
  logic signed [c_SUM_W-1:0] r_sum;
  logic [15:0]              r_data;
  logic                     r_valid;
  logic                     r_overrun;

  logic [FCW_W-1:0]   w_acc_cur;
  logic [15:0]        w_a;
  logic [15:0]        w_tri_t;
  logic [15:0]        w_wave;
  logic signed [32:0] w_wave_x;
  logic signed [32:0] w_amp_x;
  logic signed [32:0] w_prod;
  logic signed [15:0] w_scaled;
  logic [15:0]        w_lfsr_next;

  // Shadow view including this cycle's cfg write, so a write coincident with
  // an accepted tick lands in the active copy.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_sh_wave[i]  = r_sh_wave[i];
      w_sh_fcw[i]   = r_sh_fcw[i];
      w_sh_phase[i] = r_sh_phase[i];
      w_sh_amp[i]   = r_sh_amp[i];
    end
    if (i_cfg_we) begin
      case (i_cfg_sel)
        2'd0:    w_sh_wave[i_cfg_ch]  = i_cfg_data[2:0];
        2'd1:    w_sh_fcw[i_cfg_ch]   = i_cfg_data;
        2'd2:    w_sh_phase[i_cfg_ch] = i_cfg_data[15:0];
        default: w_sh_amp[i_cfg_ch]   = i_cfg_data[15:0];
      endcase
    end
  end

  always_comb begin
    w_acc_cur   = r_acc[r_ch];
    w_a         = w_acc_cur[FCW_W-1 -: 16] + r_act_phase[r_ch];
    w_tri_t     = {w_a[14:0], 1'b0};
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
    case (r_act_wave[r_ch])
      3'd1:    w_wave = w_a ^ 16'h8000;
      3'd2:    w_wave = w_a[15] ? 16'h8001 : 16'h7FFF;
      3'd3:    w_wave = w_a[15] ? (~w_tri_t ^ 16'h8000) : (w_tri_t ^ 16'h8000);
      3'd4:    w_wave = r_lfsr;
      default: w_wave = 16'h0000;
    endcase
    w_wave_x = {{17{w_wave[15]}}, w_wave};
    w_amp_x  = {17'd0, r_act_amp[r_ch]};
    w_prod   = w_wave_x * w_amp_x;
    w_scaled = 16'(w_prod >>> 16);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_sample_tick) w_state_next = ST_RUN;
      ST_RUN:  if (r_ch == CH_W'(N_CH - 1)) w_state_next = ST_OUT;
      ST_OUT:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_sh_wave[i]   <= '0;
        r_sh_fcw[i]    <= '0;
        r_sh_phase[i]  <= '0;
        r_sh_amp[i]    <= '0;
        r_act_wave[i]  <= '0;
        r_act_fcw[i]   <= '0;
        r_act_phase[i] <= '0;
        r_act_amp[i]   <= '0;
        r_acc[i]       <= '0;
      end
      r_ch      <= '0;
      r_lfsr    <= c_LFSR_SEED;
      r_sum     <= '0;
      r_data    <= 16'h8000;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_sh_wave[i]  <= w_sh_wave[i];
        r_sh_fcw[i]   <= w_sh_fcw[i];
        r_sh_phase[i] <= w_sh_phase[i];
        r_sh_amp[i]   <= w_sh_amp[i];
      end
      if (i_sample_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_sample_tick) begin
            for (int i = 0; i < N_CH; i++) begin
              r_act_wave[i]  <= w_sh_wave[i];
              r_act_fcw[i]   <= w_sh_fcw[i];
              r_act_phase[i] <= w_sh_phase[i];
              r_act_amp[i]   <= w_sh_amp[i];
            end
            r_sum <= '0;
            r_ch  <= '0;
          end
        end
        ST_RUN: begin
          r_acc[r_ch] <= w_acc_cur + r_act_fcw[r_ch];
          r_lfsr      <= w_lfsr_next;
          r_sum       <= r_sum + {{CH_W{w_scaled[15]}}, w_scaled};
          r_ch        <= r_ch + CH_W'(1);
        end
        ST_OUT: begin
          r_data  <= 16'(r_sum >>> CH_W) ^ 16'h8000;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_osc_bank_mixer.sv
`default_nettype none
// ============================================================================
// tb_osc_bank_mixer: directed-vector bench for osc_bank_mixer (N_CH=4).
// Rev 1.0
// ============================================================================
module tb_osc_bank_mixer;

  localparam int N_CH  = 4;
  localparam int FCW_W = 24;

  logic        r_clk = 1'b0;
  logic        r_rst_n;
  logic        r_tick;
  logic        r_we;
  logic [1:0]  r_ch;
  logic [1:0]  r_sel;
  logic [23:0] r_cfg;
  logic [15:0] w_data;
  logic        w_valid;
  logic        w_busy;
  logic        w_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  osc_bank_mixer #(.N_CH(N_CH), .FCW_W(FCW_W)) u_dut (
    .i_clk         (r_clk),
    .i_rst_n       (r_rst_n),
    .i_sample_tick (r_tick),
    .i_cfg_we      (r_we),
    .i_cfg_ch      (r_ch),
    .i_cfg_sel     (r_sel),
    .i_cfg_data    (r_cfg),
    .o_data        (w_data),
    .o_valid       (w_valid),
    .o_busy        (w_busy),
    .o_overrun     (w_overrun)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    r_rst_n = 1'b0;
    step();
    step();
    r_rst_n = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [23:0] d);
    r_we = 1'b1; r_ch = ch; r_sel = sel; r_cfg = d;
    step();
    r_we = 1'b0;
  endtask

  // Tick, optionally with a coincident cfg write; checks busy/latency and
  // returns the frame's sample. b2b leaves the bench in the o_valid cycle.
  task automatic run_frame(input string tag, input logic [15:0] exp,
                           input bit with_cfg, input logic [1:0] ch,
                           input logic [1:0] sel, input logic [23:0] d,
                           input bit b2b);
    int n;
    r_tick = 1'b1;
    if (with_cfg) begin r_we = 1'b1; r_ch = ch; r_sel = sel; r_cfg = d; end
    step();
    r_tick = 1'b0;
    r_we   = 1'b0;
    n = 1;
    while (!w_valid && n < 20) begin
      if (n <= N_CH + 1 && w_busy !== 1'b1) check({tag, "_busy_hi"}, 32'(w_busy), 32'd1);
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(N_CH + 2));
    check({tag, "_busy_lo"}, 32'(w_busy), 32'd0);
    check({tag, "_data"}, 32'(w_data), 32'(exp));
    if (!b2b) begin
      step();
      check({tag, "_valid_pulse"}, 32'(w_valid), 32'd0);
    end
  endtask

  initial begin
    int nv;
    r_rst_n = 1'b0; r_tick = 1'b0; r_we = 1'b0; r_ch = '0; r_sel = '0; r_cfg = '0;

    // Reset state, then an all-off frame
    do_reset();
    check("rst_data", 32'(w_data), 32'h8000);
    check("rst_valid", 32'(w_valid), 32'd0);
    check("rst_busy", 32'(w_busy), 32'd0);
    check("rst_overrun", 32'(w_overrun), 32'd0);
    run_frame("off", 16'h8000, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);

    // Saw on ch0, three frames, first two followed back-to-back
    do_reset();
    cfg(2'd0, 2'd0, 24'd1);
    cfg(2'd0, 2'd1, 24'h010000);
    cfg(2'd0, 2'd3, 24'h00FFFF);
    run_frame("saw0", 16'h6000, 1'b0, 2'd0, 2'd0, 24'd0, 1'b1);
    run_frame("saw1", 16'h6040, 1'b0, 2'd0, 2'd0, 24'd0, 1'b1);
    run_frame("saw2", 16'h6080, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);
    check("b2b_overrun", 32'(w_overrun), 32'd0);

    // All channels full-scale square
    do_reset();
    for (int c = 0; c < N_CH; c++) begin
      cfg(2'(c), 2'd0, 24'd2);
      cfg(2'(c), 2'd3, 24'h00FFFF);
    end
    run_frame("sq0", 16'hFFFE, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);
    run_frame("sq1", 16'hFFFE, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);

    // Triangle at phase 0x8000; amp cleared in the tick cycle takes effect
    do_reset();
    cfg(2'd0, 2'd0, 24'd3);
    cfg(2'd0, 2'd2, 24'h008000);
    cfg(2'd0, 2'd3, 24'h00FFFF);
    run_frame("tri", 16'h9FFF, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);
    run_frame("tri_amp0", 16'h8000, 1'b1, 2'd0, 2'd3, 24'd0, 1'b0);

    // Second tick while busy: one frame, sticky overrun
    do_reset();
    r_tick = 1'b1; step(); r_tick = 1'b0;
    step();
    r_tick = 1'b1; step(); r_tick = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (w_valid) nv++;
      step();
    end
    check("ovr_valid_count", 32'(nv), 32'd1);
    check("ovr_flag", 32'(w_overrun), 32'd1);
    run_frame("ovr_next", 16'h8000, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);
    check("ovr_sticky", 32'(w_overrun), 32'd1);
    do_reset();
    check("ovr_cleared", 32'(w_overrun), 32'd0);

    // Reset dropped mid-frame, then a fresh frame from acc=0
    cfg(2'd0, 2'd0, 24'd1);
    cfg(2'd0, 2'd1, 24'h010000);
    cfg(2'd0, 2'd3, 24'h00FFFF);
    r_tick = 1'b1; step(); r_tick = 1'b0;
    step();
    step();
    r_rst_n = 1'b0; step(); r_rst_n = 1'b1;
    check("abort_busy", 32'(w_busy), 32'd0);
    check("abort_data", 32'(w_data), 32'h8000);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (w_valid) nv++;
      step();
    end
    check("abort_no_valid", 32'(nv), 32'd0);
    cfg(2'd0, 2'd0, 24'd1);
    cfg(2'd0, 2'd1, 24'h010000);
    cfg(2'd0, 2'd3, 24'h00FFFF);
    run_frame("fresh", 16'h6000, 1'b0, 2'd0, 2'd0, 24'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/osc_bank_mixer.md
# osc_bank_mixer

Parametrised, time-multiplexed oscillator bank: N_CH independent channels share one phase/waveform/amplitude datapath, are evaluated sequentially once per sample tick, and are summed, scaled by 1/N_CH, and emitted as one unsigned offset-binary sample. It sits between the SPI-driven control logic (config write port) and the audio output. It replaces per-channel instantiation of separate accumulator, wave, mux, converter and amplifier blocks with a single shared datapath.

## Interface
- N_CH, 4: channel count; power of two, 2..16. CH_W = log2(N_CH).
- FCW_W, 24: frequency control word / phase accumulator width; ≥17.
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_sample_tick  in  1  one-cycle pulse; starts a frame
- i_cfg_we  in  1  config write strobe
- i_cfg_ch  in  CH_W  target channel
- i_cfg_sel  in  2  0 wave[2:0], 1 fcw[FCW_W-1:0], 2 phase offset[15:0], 3 amp[15:0]
- i_cfg_data  in  FCW_W  write data, LSB-aligned; unused upper bits ignored
- o_data  out  16  mixed sample, unsigned offset binary
- o_valid  out  1  one-cycle pulse: o_data updated
- o_busy  out  1  frame in progress
- o_overrun  out  1  sticky: tick arrived while busy

## Operation
- Per channel: shadow regs (written by cfg port any cycle) and active regs (copied from shadow at frame start), plus phase accumulator acc[FCW_W].
- Wave codes: 0 off (sample 0), 1 saw, 2 square, 3 triangle, 4 noise, 5–7 off.
- FSM IDLE → RUN → OUT → IDLE.
  - IDLE: on i_sample_tick copy all shadow→active, clear mix sum, ch=0, go RUN. A cfg write in the same cycle as an accepted tick is included in the copy.
  - RUN: one channel per cycle, ch = 0..N_CH-1; after ch=N_CH-1 go OUT.
  - OUT: register output, pulse o_valid, go IDLE.
- Channel slot: a = acc[FCW_W-1:FCW_W-16] + phase (mod 2^16), computed from acc before update; then acc += fcw (mod 2^FCW_W). Accumulators advance for all channels including off ones; writing fcw never resets acc.
- Waveforms, signed 16-bit: saw = a ^ 0x8000; square = a[15] ? 0x8001 : 0x7FFF; triangle: t = {a[14:0],1'b0}, a[15]=0 → t ^ 0x8000, a[15]=1 → ~t ^ 0x8000; noise = LFSR state as signed.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, seed 0xACE1, advances every RUN cycle regardless of wave.
- Scaling: scaled = (s16 × {1'b0,amp}) >>> 16 (arithmetic, floor); range −32768..32766.
- Mix: signed sum, width 16+CH_W, no saturation needed. OUT: o_data = (sum >>> CH_W)[15:0] ^ 0x8000.
- i_sample_tick while o_busy: ignored, o_overrun ← 1 (cleared only by reset).

## Timing
- Reset (i_rst_n=0 at edge): all shadow/active regs 0, acc 0, LFSR 0xACE1, FSM IDLE; o_data 0x8000, o_valid 0, o_busy 0, o_overrun 0. Reset mid-frame aborts the frame, no o_valid.
- Tick accepted at edge T: o_busy=1 from T+1 through T+N_CH+1; RUN at T+1..T+N_CH; o_valid=1 and new o_data at T+N_CH+2; o_busy=0 that cycle.
- Back-to-back: next tick accepted earliest at edge where o_valid is high (minimum tick period N_CH+2).
- o_data held between frames; o_valid exactly one cycle per frame.
- Cfg writes during RUN affect shadow only; active values constant within a frame.

## Test plan
- Reset then tick with all channels off (N_CH=4) → o_valid at T+6, o_data=0x8000, o_busy high T+1..T+5.
- ch0 saw, fcw=0x010000, amp=0xFFFF, others off; three ticks → o_data 0x6000, 0x6040, 0x6080.
- All 4 channels square, amp=0xFFFF, phase 0, fcw 0 → o_data=0xFFFE every frame.
- ch0 triangle, fcw 0, phase 0x8000, amp 0xFFFF → o_data=0x9FFF; rewrite amp=0 in same cycle as next tick → that frame o_data=0x8000.
- Tick at T, second tick at T+2 → one o_valid only, o_overrun=1 and stays 1 until reset.
- Drop i_rst_n during RUN (T+3) → next cycle o_busy=0, o_data=0x8000, no o_valid; fresh tick then produces correct frame from acc=0.
